// File: rtl/mt_pkg.sv
// Shared definitions for the multithreaded register file:
// default thread geometry, clear-FSM encoding, clog2 helper.
package mt_pkg;

    localparam int MT_NTHREADS = 4;
    localparam int MT_THREAD_W = 2;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_SWEEP = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mt_regfile_clr_fsm.sv
// Per-thread clear sequencer: sweeps one bank, one entry
// per cycle, then pulses done for a single cycle.
module mt_regfile_clr_fsm
    import mt_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int THREAD_W = MT_THREAD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_req,
    input  logic [THREAD_W-1:0] clr_thread,
    output logic                clr_busy,
    output logic                clr_done,
    output logic                clr_en,
    output logic [THREAD_W-1:0] ctid,
    output logic [ADDR_W-1:0]   cidx
);

    clr_state_e          state;
    clr_state_e          state_n;
    logic [THREAD_W-1:0] ctid_n;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W-1:0]   idx_n;

    // State, target bank and sweep index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLR_IDLE;
            ctid  <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            ctid  <= ctid_n;
            idx   <= idx_n;
        end
    end

    // Next-state logic; the last index of the bank ends the sweep.
    always_comb begin
        state_n = state;
        ctid_n  = ctid;
        idx_n   = idx;
        unique case (state)
            CLR_IDLE: begin
                if (clr_req) begin
                    ctid_n  = clr_thread;
                    idx_n   = '0;
                    state_n = CLR_SWEEP;
                end
            end
            CLR_SWEEP: begin
                idx_n = idx + ADDR_W'(1);
                if (&idx) state_n = CLR_DONE;
            end
            CLR_DONE: state_n = CLR_IDLE;
            default:  state_n = CLR_IDLE;
        endcase
    end

    // Status and clear strobe are pure functions of state.
    always_comb begin
        clr_busy = (state == CLR_SWEEP);
        clr_done = (state == CLR_DONE);
        clr_en   = clr_busy;
        cidx     = idx;
    end

endmodule

// File: rtl/mt_regfile.sv
// Barrel-threaded register file: one bank per thread, two
// forwarding read ports, one write port, per-bank clear.
module mt_regfile
    import mt_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 3,
    parameter int NTHREADS  = MT_NTHREADS,
    parameter int THREAD_W  = MT_THREAD_W,
    parameter int REG0_ZERO = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [THREAD_W-1:0] rthread,
    input  logic [ADDR_W-1:0]   r0addr,
    input  logic [ADDR_W-1:0]   r1addr,
    output logic [DATA_W-1:0]   r0data,
    output logic [DATA_W-1:0]   r1data,
    input  logic                wena,
    input  logic [THREAD_W-1:0] wthread,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                clr_req,
    input  logic [THREAD_W-1:0] clr_thread,
    output logic                clr_busy,
    output logic                clr_done,
    output logic                wdrop
);

    localparam int NREGS = 1 << ADDR_W;
    localparam logic [THREAD_W:0] NT = NTHREADS[THREAD_W:0];
    localparam bit Z = (REG0_ZERO != 0);

    if (THREAD_W != clog2(NTHREADS) || NTHREADS < 2) begin : g_bad_geom
        $error("THREAD_W must equal clog2(NTHREADS), NTHREADS >= 2");
    end

    logic [DATA_W-1:0]   mem [NTHREADS][NREGS];
    logic                clr_en;
    logic [THREAD_W-1:0] ctid;
    logic [ADDR_W-1:0]   cidx;
    logic                rvalid;
    logic                wvalid;
    logic                cvalid;
    logic                whit;
    logic                wacc;

    mt_regfile_clr_fsm #(
        .ADDR_W   (ADDR_W),
        .THREAD_W (THREAD_W)
    ) u_clr (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (clr_req),
        .clr_thread (clr_thread),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .clr_en     (clr_en),
        .ctid       (ctid),
        .cidx       (cidx)
    );

    // Thread validity and write acceptance; writes into the bank
    // being swept are dropped so the sweep leaves it all zero.
    always_comb begin
        rvalid = ({1'b0, rthread} < NT);
        wvalid = ({1'b0, wthread} < NT);
        cvalid = ({1'b0, ctid} < NT);
        whit   = wena && wvalid && clr_busy && (wthread == ctid);
        wacc   = wena && wvalid && !whit && !(Z && waddr == '0);
    end

    // Read port 0 with same-cycle forwarding of accepted writes.
    always_comb begin
        r0data = '0;
        if (rvalid && !(Z && r0addr == '0)) begin
            if (wacc && wthread == rthread && waddr == r0addr)
                r0data = wdata;
            else
                r0data = mem[rthread][r0addr];
        end
    end

    // Read port 1 with same-cycle forwarding of accepted writes.
    always_comb begin
        r1data = '0;
        if (rvalid && !(Z && r1addr == '0)) begin
            if (wacc && wthread == rthread && waddr == r1addr)
                r1data = wdata;
            else
                r1data = mem[rthread][r1addr];
        end
    end

    // Bank storage: reset wipes everything, otherwise write port
    // and clear strobe (always different banks) update in parallel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NTHREADS; t++)
                for (int a = 0; a < NREGS; a++)
                    mem[t][a] <= '0;
        end else begin
            if (wacc)
                mem[wthread][waddr] <= wdata;
            if (clr_en && cvalid)
                mem[ctid][cidx] <= '0;
        end
    end

    // Sticky flag for writes lost to an in-progress clear.
    always_ff @(posedge clk) begin
        if (rst)       wdrop <= 1'b0;
        else if (whit) wdrop <= 1'b1;
    end

endmodule

// File: doc/mt_regfile.md
Name: mt_regfile

Overview:
- Parametrised multithreaded register file for the barrel-threaded datapath: NTHREADS independent banks of NREGS x DATA_W registers.
- Reads (decode stage) and writes (write-back stage) carry independent thread IDs, so write-back of one thread overlaps decode of another.
- Adds write-to-read forwarding, optional hardwired-zero R0, and a per-thread clear sequencer so one thread's context is wiped without disturbing the others.

Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W
- NTHREADS, 4, number of thread banks (>=2)
- THREAD_W, 2, thread ID width; must equal clog2(NTHREADS)
- REG0_ZERO, 0, 1 = register 0 of every bank reads 0 and ignores writes

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rthread  in  THREAD_W  thread ID for both read ports
- r0addr  in  ADDR_W  read port 0 address
- r1addr  in  ADDR_W  read port 1 address
- r0data  out  DATA_W  read port 0 data (combinational)
- r1data  out  DATA_W  read port 1 data (combinational)
- wena  in  1  write enable
- wthread  in  THREAD_W  write thread ID
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- clr_req  in  1  request to clear one thread bank
- clr_thread  in  THREAD_W  bank to clear, sampled with clr_req
- clr_busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse when the sweep completes
- wdrop  out  1  sticky: a write was discarded because its bank was being cleared

Behaviour:
- Reset: when rst=1 at an edge, all entries of all banks become 0. FSM goes to IDLE; clr_busy=0, clr_done=0, wdrop=0. rst overrides every other input, including mid-sweep; no clr_done is issued.
- Write: when wena=1, wdata is stored at bank[wthread][waddr] at the edge. It is visible to plain reads from the next cycle.
- Thread IDs >= NTHREADS are invalid: writes are ignored and reads return 0.
- Read: rNdata = bank[rthread][rNaddr], combinational, zero-latency.
- Forwarding: if wena=1, wthread==rthread, waddr==rNaddr and the write is accepted, rNdata = wdata in the same cycle (new value, not old).
- REG0_ZERO=1: address 0 always reads 0, is never forwarded, and writes to it are ignored.
- Clear FSM, states IDLE, SWEEP, DONE:
  - IDLE: clr_req=1 latches clr_thread into ctid, sets idx=0, goes to SWEEP.
  - SWEEP: clr_busy=1. Each edge clears bank[ctid][idx] and increments idx. When idx==NREGS-1 the next state is DONE. Duration is exactly NREGS cycles.
  - DONE: clr_busy=0, clr_done=1 for one cycle, then IDLE.
- Timing example: request accepted at edge T → busy in cycles T+1..T+NREGS → done in cycle T+NREGS+1.
- clr_req in SWEEP or DONE is ignored (not queued). The requester holds or reissues after clr_done.
- Writes to bank ctid while in SWEEP are discarded (not forwarded) and set wdrop, which is cleared only by rst. Writes to other banks proceed normally.
- Reads of bank ctid during SWEEP return current storage contents: 0 for entries already swept, old values for the rest.
- A write whose wthread matches a clr_thread being accepted in the same IDLE cycle is performed; the sweep then clears it.

Decomposition:
- Shared package mt_pkg: THREAD_W/NTHREADS defaults, the clear-FSM state encoding (IDLE=2'd0, SWEEP=2'd1, DONE=2'd2), and a clog2 function.
- One natural sub-module: mt_regfile_clr_fsm. It owns the state, ctid, idx, clr_busy, clr_done, and the per-cycle clear strobe and address.
- Bank array, write decode and read/forward muxes stay in mt_regfile.

Test Plan:
- Reset then read: pulse rst; read all 4 threads x 8 addrs → all r0data/r1data = 0, clr_busy=0, wdrop=0.
- Thread isolation: write T0 R3=0x11, T1 R3=0x22, T3 R3=0x44; read rthread=1 r0addr=3 → 0x22; rthread=2 → 0.
- Forwarding: wena=1, wthread=2, waddr=5, wdata=0xDEAD with rthread=2, r1addr=5 in the same cycle → r1data=0xDEAD. With rthread=1 → the T1 R5 value.
- Clear sweep: fill T1 R0..R7 = 1..8, clr_req with clr_thread=1 at edge T → clr_busy for 8 cycles, clr_done at T+9, all T1 regs = 0, T0 unchanged. Mid-sweep T1 write → dropped, wdrop=1; concurrent T3 write succeeds.
- Reset mid-sweep: rst at 3rd busy cycle → next cycle clr_busy=0, no clr_done, all banks 0. A later clr_req is accepted normally.
- REG0_ZERO=1 build: write T0 R0=0xFF → r0data(addr 0)=0, both same-cycle and next cycle.
